md5_block_builder: RTL and testbench

Producer side of the MD5 block interface: forms the single 512-bit MD5 message block for each candidate string `key || decimal(n)`, for n = 1, 2, 3, …, and streams the blocks over the ready/valid interface that the MD5 engine consumes. It counts in BCD, applies MD5 padding and the length field, and sustains one block per cycle under continuous `ready`. Every message fits in the first 128 bits of the block, so the engine's header capture recovers the answer string directly.

---
 rtl/md5_block_builder.sv | 145 ++++++++++++++
 tb/tb_md5_block_builder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/md5_block_builder.sv
// Streams one padded 512-bit MD5 block per candidate "key || decimal(n)", n = 1, 2, ...
// BCD counter plus combinational block former; one block per cycle under continuous ready.
module md5_block_builder #(
  parameter int BLOCK_WIDTH   = 512,
  parameter int KEY_MAX_CHARS = 8,
  parameter int DIGITS        = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic                                 key_ready,
  input  logic                                 key_valid,
  input  logic [8*KEY_MAX_CHARS-1:0]           key_data,
  input  logic [$clog2(KEY_MAX_CHARS+1)-1:0]   key_length,
  input  logic                                 stop,
  input  logic                                 md5_block_ready,
  output logic                                 md5_block_valid,
  output logic [BLOCK_WIDTH-1:0]               md5_block_data,
  output logic                                 done
);

  localparam int KLW = $clog2(KEY_MAX_CHARS + 1);
  localparam int NDW = $clog2(DIGITS + 1);
  localparam logic [4*DIGITS-1:0] BCD_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [8*KEY_MAX_CHARS-1:0] r_key;
  logic [KLW-1:0]           r_klen;
  logic [4*DIGITS-1:0]      r_bcd;
  logic [NDW-1:0]           r_ndig;
  logic                     r_valid;
  logic [BLOCK_WIDTH-1:0]   r_data;

  logic                     w_load, w_xfer, w_all_nines, w_terminal, w_end_run;
  logic [KLW-1:0]           w_klen_sat;
  logic [4*DIGITS-1:0]      w_bcd_inc;
  logic [NDW-1:0]           w_ndig_inc;
  logic [8*KEY_MAX_CHARS-1:0] w_src_key;
  logic [KLW-1:0]           w_src_klen;
  logic [4*DIGITS-1:0]      w_src_bcd;
  logic [NDW-1:0]           w_src_ndig;
  logic [BLOCK_WIDTH-1:0]   w_block;

  // Message always lies in bytes 0..16, so only byte 56 of the length field can be nonzero.
  function automatic logic [BLOCK_WIDTH-1:0] build_block(
    input logic [8*KEY_MAX_CHARS-1:0] key,
    input int                         klen,
    input logic [4*DIGITS-1:0]        bcd,
    input int                         ndig
  );
    logic [BLOCK_WIDTH-1:0] blk;
    int len;
    blk = '0;
    len = klen + ndig;
    for (int i = 0; i < KEY_MAX_CHARS; i++) begin
      if (i < klen) blk[BLOCK_WIDTH-1-8*i -: 8] = key[8*(KEY_MAX_CHARS-1-i) +: 8];
    end
    for (int d = 0; d < DIGITS; d++) begin
      if (d < ndig) blk[BLOCK_WIDTH-1-8*(klen+d) -: 8] = {4'h3, bcd[4*(ndig-1-d) +: 4]};
    end
    blk[BLOCK_WIDTH-1-8*len -: 8]  = 8'h80;
    blk[BLOCK_WIDTH-1-8*56 -: 8]   = 8'(8 * len);
    return blk;
  endfunction

  assign w_load     = key_valid & key_ready;
  assign w_xfer     = r_valid & md5_block_ready;
  assign w_klen_sat = (key_length > KLW'(KEY_MAX_CHARS)) ? KLW'(KEY_MAX_CHARS) : key_length;

  always_comb begin
    logic c;
    w_bcd_inc   = r_bcd;
    w_all_nines = 1'b1;
    c           = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (r_bcd[4*d +: 4] == 4'd9) begin
          w_bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
      if ((d < int'(r_ndig)) && (r_bcd[4*d +: 4] != 4'd9)) w_all_nines = 1'b0;
    end
  end

  assign w_ndig_inc = w_all_nines ? (r_ndig + 1'b1) : r_ndig;
  assign w_terminal = w_all_nines && (r_ndig == NDW'(DIGITS));
  assign w_end_run  = stop || (w_xfer && w_terminal);

  // A key load reuses the single block former with n = 1.
  assign w_src_key  = w_load ? key_data   : r_key;
  assign w_src_klen = w_load ? w_klen_sat : r_klen;
  assign w_src_bcd  = w_load ? BCD_ONE    : w_bcd_inc;
  assign w_src_ndig = w_load ? NDW'(1)    : w_ndig_inc;
  assign w_block    = build_block(w_src_key, int'(w_src_klen), w_src_bcd, int'(w_src_ndig));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (key_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_end_run) w_state_nxt = S_DONE;
      S_DONE:  if (key_valid) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_klen  <= '0;
      r_bcd   <= '0;
      r_ndig  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_key   <= key_data;
        r_klen  <= w_klen_sat;
        r_bcd   <= BCD_ONE;
        r_ndig  <= NDW'(1);
        r_data  <= w_block;
        r_valid <= 1'b1;
      end else if (r_state == S_RUN) begin
        if (w_end_run) begin
          r_valid <= 1'b0;
        end else if (w_xfer) begin
          r_bcd  <= w_bcd_inc;
          r_ndig <= w_ndig_inc;
          r_data <= w_block;
        end
      end
    end
  end

  assign key_ready       = (r_state != S_RUN);
  assign done            = (r_state == S_DONE);
  assign md5_block_valid = r_valid;
  assign md5_block_data  = r_data;

endmodule

// File: tb/tb_md5_block_builder.sv
// Directed bench for md5_block_builder: default build plus a two-digit build for overflow.
module tb_md5_block_builder;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic         reset, key_ready, key_valid, stop, md5_block_ready, md5_block_valid, done;
  logic [63:0]  key_data;
  logic [3:0]   key_length;
  logic [511:0] md5_block_data;

  // DUT B: DIGITS = 2
  logic         b_reset, b_key_ready, b_key_valid, b_stop, b_ready, b_valid, b_done;
  logic [63:0]  b_key_data;
  logic [3:0]   b_key_length;
  logic [511:0] b_data;

  md5_block_builder dut_a (
    .clk(clk), .reset(reset), .key_ready(key_ready), .key_valid(key_valid),
    .key_data(key_data), .key_length(key_length), .stop(stop),
    .md5_block_ready(md5_block_ready), .md5_block_valid(md5_block_valid),
    .md5_block_data(md5_block_data), .done(done)
  );

  md5_block_builder #(.DIGITS(2)) dut_b (
    .clk(clk), .reset(b_reset), .key_ready(b_key_ready), .key_valid(b_key_valid),
    .key_data(b_key_data), .key_length(b_key_length), .stop(b_stop),
    .md5_block_ready(b_ready), .md5_block_valid(b_valid),
    .md5_block_data(b_data), .done(b_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference block built from the candidate string itself.
  function automatic logic [511:0] exp_block(input string key, input int n);
    string s;
    logic [511:0] b;
    int L;
    s = {key, $sformatf("%0d", n)};
    L = s.len();
    b = '0;
    for (int i = 0; i < L; i++) b[511-8*i -: 8] = s[i];
    b[511-8*L -: 8]  = 8'h80;
    b[511-8*56 -: 8] = 8'(8 * L);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_valid"},     512'(md5_block_valid), 512'd0);
    check({tag, "_data"},      md5_block_data,        512'd0);
    check({tag, "_key_ready"}, 512'(key_ready),       512'd1);
    check({tag, "_done"},      512'(done),            512'd0);
  endtask

  logic [511:0] hc_n1, hc_n10;

  initial begin
    hc_n1  = (512'h6162636465663180 << 448) | (512'h38 << 56);
    hc_n10 = (512'h616263646566313080 << 440) | (512'h40 << 56);

    reset = 1'b0; key_valid = 1'b0; stop = 1'b0; md5_block_ready = 1'b0;
    key_data = '0; key_length = '0;
    b_reset = 1'b0; b_key_valid = 1'b0; b_stop = 1'b0; b_ready = 1'b0;
    b_key_data = '0; b_key_length = '0;
    #1;
    tick(); tick();
    check_reset_a("rst");
    reset = 1'b1;

    // stop in IDLE must be ignored
    stop = 1'b1; tick(); stop = 1'b0;
    check("idle_stop_done",  512'(done),      512'd0);
    check("idle_stop_kr",    512'(key_ready), 512'd1);

    // first block
    key_data = {"abcdef", 16'h0}; key_length = 4'd6; key_valid = 1'b1;
    md5_block_ready = 1'b1;
    tick(); key_valid = 1'b0;
    check("n1_valid", 512'(md5_block_valid), 512'd1);
    check("n1_data",  md5_block_data,        hc_n1);
    check("n1_kr",    512'(key_ready),       512'd0);
    tick();
    check("n2_data",  md5_block_data, exp_block("abcdef", 2));
    tick();
    check("n3_data",  md5_block_data, exp_block("abcdef", 3));

    // backpressure on n = 3, with an ignored key offer during RUN
    md5_block_ready = 1'b0;
    key_valid = 1'b1; key_data = {"zzzz", 32'h0}; key_length = 4'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data",  md5_block_data,        exp_block("abcdef", 3));
      check("bp_valid", 512'(md5_block_valid), 512'd1);
    end
    key_valid = 1'b0;
    md5_block_ready = 1'b1;
    tick();
    check("bp_n4", md5_block_data, exp_block("abcdef", 4));

    // digit growth 9 -> 10
    repeat (6) tick();
    check("n10_data", md5_block_data, hc_n10);

    repeat (32) tick();
    check("n42_data", md5_block_data, exp_block("abcdef", 42));

    // stop together with the transfer of n = 42
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_valid", 512'(md5_block_valid), 512'd0);
    check("stop_done",  512'(done),            512'd1);
    check("stop_kr",    512'(key_ready),       512'd1);
    tick();
    check("stop_hold_valid", 512'(md5_block_valid), 512'd0);

    // restart from DONE
    key_data = {"xyz", 40'h0}; key_length = 4'd3; key_valid = 1'b1;
    tick(); key_valid = 1'b0;
    check("restart_data",  md5_block_data, exp_block("xyz", 1));
    check("restart_done",  512'(done),     512'd0);
    tick();
    check("restart_n2",    md5_block_data, exp_block("xyz", 2));

    // reset while valid & !ready
    md5_block_ready = 1'b0;
    tick();
    reset = 1'b0; tick(); reset = 1'b1;
    check_reset_a("midrst");

    // DIGITS = 2 build, 8-char key with saturating length
    b_reset = 1'b1; tick();
    b_key_data = "ABCDEFGH"; b_key_length = 4'd15; b_key_valid = 1'b1; b_ready = 1'b1;
    tick(); b_key_valid = 1'b0;
    for (int n = 1; n <= 99; n++) begin
      check($sformatf("ovf_n%0d", n), b_data, exp_block("ABCDEFGH", n));
      if (!b_valid) check("ovf_valid_drop", 512'(b_valid), 512'd1);
      if (n == 99) check("ovf_len_byte", 512'(b_data[63:56]), 512'h50);
      tick();
    end
    check("ovf_valid", 512'(b_valid), 512'd0);
    check("ovf_done",  512'(b_done),  512'd1);
    check("ovf_kr",    512'(b_key_ready), 512'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
